// File: rtl/vga_frame_capture.sv
// vga_frame_capture
//
// Captures one complete active frame of a VGA-timed greyscale stream into
// video memory. The frame is written linearly from a base address chosen by
// image_select, matching the layout the display side reads from, so a
// captured image can be shown unchanged.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   pix_en             pixel strobe; video inputs are sampled only when 1
//   hsync, vsync       active-low syncs (only vsync edges are used)
//   blank_b            1 = active pixel; a falling edge ends a line
//   pixel              greyscale pixel value
//   image_select       chooses FRAME_BASE0/1, latched when start is accepted
//   start              one-cycle request to capture the next full frame
//   wr_ready           memory accepts the pending write this cycle
//   wr_en/wr_address/wr_data   single-entry write holding register
//   busy               capture in progress
//   done               one-cycle pulse when a capture ends
//   line_err           sticky: a line did not carry exactly H_ACTIVE pixels
//   frame_err          sticky: vsync arrived before V_ACTIVE lines
//   overrun            sticky: a pixel arrived while a write was still pending
module vga_frame_capture #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic [31:0] FRAME_BASE0 = 32'h0000_0000,
    parameter logic [31:0] FRAME_BASE1 = 32'h0004_B000,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              blank_b,
    input  logic [DATA_W-1:0] pixel,
    input  logic              image_select,
    input  logic              start,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [31:0]       wr_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              line_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam logic [15:0] H_MAX  = 16'(H_ACTIVE);
    localparam logic [15:0] V_MAX  = 16'(V_ACTIVE);
    localparam logic [31:0] H_STEP = 32'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FINISH} state_t;

    state_t            state_q, state_d;
    logic              vsync_q, blank_q;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic              line_ovf_q, line_ovf_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       line_addr_q, line_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    // Horizontal sync carries no information the capture needs; line ends
    // are taken from blank_b instead.
    logic unused_hsync;
    assign unused_hsync = hsync;

    // Edge events, valid only on pixel-strobe cycles.
    logic vs_fall, bl_fall, in_cap, act, pix_wr, pix_extra;
    logic line_end, frame_full, frame_short, start_acc;
    logic [15:0] y_inc, y_after;

    assign vs_fall     = pix_en && vsync_q && !vsync;
    assign bl_fall     = pix_en && blank_q && !blank_b;
    assign in_cap      = (state_q == CAPTURE);
    assign act         = in_cap && pix_en && blank_b;
    assign pix_wr      = act && (x_q < H_MAX);
    assign pix_extra   = act && (x_q >= H_MAX);
    assign line_end    = in_cap && bl_fall;
    assign y_inc       = y_q + 16'd1;
    assign frame_full  = line_end && (y_inc == V_MAX);
    // Line-end processing takes precedence over a coincident vsync edge.
    assign y_after     = line_end ? y_inc : y_q;
    assign frame_short = in_cap && vs_fall && (y_after < V_MAX);
    assign start_acc   = (state_q == IDLE) && start;

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b1;
            blank_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            line_ovf_q  <= 1'b0;
            base_q      <= '0;
            line_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (pix_en) begin
                vsync_q <= vsync;
                blank_q <= blank_b;
            end
            x_q         <= x_d;
            y_q         <= y_d;
            line_ovf_q  <= line_ovf_d;
            base_q      <= base_d;
            line_addr_q <= line_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARMED;
            ARMED:   if (vs_fall) state_d = CAPTURE;
            CAPTURE: if (frame_full || frame_short) state_d = FINISH;
            FINISH:  if (!wr_en_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        done = (state_q == FINISH) && !wr_en_q;
        busy = (state_q != IDLE) && !done;
    end

    assign wr_en      = wr_en_q;
    assign wr_address = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    // Counters, sticky flags and write holding register
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        line_ovf_d  = line_ovf_q;
        base_d      = base_q;
        line_addr_d = line_addr_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (start_acc) begin
            base_d      = image_select ? FRAME_BASE1 : FRAME_BASE0;
            line_err_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if ((state_q == ARMED) && vs_fall) begin
            x_d         = '0;
            y_d         = '0;
            line_ovf_d  = 1'b0;
            line_addr_d = base_q;
        end

        // The line start address is kept as a running sum, so the linear
        // address y*H_ACTIVE+x needs no multiplier.
        if (pix_wr)    x_d = x_q + 16'd1;
        if (pix_extra) line_ovf_d = 1'b1;

        if (line_end) begin
            if ((x_q != H_MAX) || line_ovf_q) line_err_d = 1'b1;
            x_d         = '0;
            y_d         = y_inc;
            line_ovf_d  = 1'b0;
            line_addr_d = line_addr_q + H_STEP;
        end

        if (frame_short) frame_err_d = 1'b1;

        // A pending write that is accepted this cycle frees the register
        // for a new pixel in the same cycle.
        if (pix_wr) begin
            if (!wr_en_q || wr_ready) begin
                wr_en_d   = 1'b1;
                wr_addr_d = line_addr_q + {16'b0, x_q};
                wr_data_d = pixel;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (wr_en_q && wr_ready) begin
            wr_en_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
module tb_vga_frame_capture;

    localparam int          H  = 8;
    localparam int          V  = 4;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0004_B000;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync, blank_b, image_select, start, wr_ready;
    logic [7:0]  pixel;
    logic        wr_en, busy, done, line_err, frame_err, overrun;
    logic [31:0] wr_address;
    logic [7:0]  wr_data;

    vga_frame_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_BASE0(B0), .FRAME_BASE1(B1), .DATA_W(8)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .blank_b(blank_b), .pixel(pixel), .image_select(image_select), .start(start),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .busy(busy), .done(done), .line_err(line_err), .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          done_cnt = 0;
    int          done_busy_bad = 0;
    int          line_len[V];

    // Record every accepted write and every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en && wr_ready) begin
                log_addr.push_back(wr_address);
                log_data.push_back(wr_data);
            end
            if (done) begin
                done_cnt++;
                if (busy) done_busy_bad++;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        done_busy_bad = 0;
    endtask

    // One pix_en sample followed by three idle clocks (pix_en every 4th clk).
    task automatic smp(input logic vs, input logic bl, input logic [7:0] px);
        vsync = vs; blank_b = bl; pixel = px; hsync = bl;
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_capture(input logic sel);
        image_select = sel;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // coincide: the last line's blank falling edge lands on a vsync falling edge.
    task automatic send_frame(input int nlines, input bit flip_sel, input bit coincide);
        smp(1, 0, 0); smp(0, 0, 0); smp(0, 0, 0); smp(1, 0, 0); smp(1, 0, 0);
        for (int l = 0; l < nlines; l++) begin
            for (int x = 0; x < line_len[l]; x++) smp(1, 1, 8'(x + l));
            if (flip_sel && l == 1) begin
                image_select = ~image_select;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (coincide && l == nlines - 1) smp(0, 0, 0);
            else smp(1, 0, 0);
            smp(1, 0, 0);
        end
        smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0);
    endtask

    task automatic build_exp(input logic [31:0] base, input int nlines);
        exp_addr.delete();
        exp_data.delete();
        for (int l = 0; l < nlines; l++)
            for (int x = 0; x < line_len[l] && x < H; x++) begin
                exp_addr.push_back(base + 32'(l * H + x));
                exp_data.push_back(8'(x + l));
            end
    endtask

    task automatic wait_idle(output bit timed_out);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_address, wr_data} !== 41'd0) begin
            failures++;
            $display("FAIL reset_write_port got en=%b addr=%h data=%h expected all 0", wr_en, wr_address, wr_data);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if ({line_err, frame_err, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got %b%b%b expected 000", line_err, frame_err, overrun);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        bit to;
        for (int l = 0; l < V; l++) line_len[l] = H;
        clear_log();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_busy_before got %b expected 0", busy);
        end
        @(posedge clk); #1;
        start_capture(1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL nominal_busy_after_start got %b expected 1", busy);
        end
        @(posedge clk); #1;
        send_frame(V, 0, 0);
        wait_idle(to);
        build_exp(B0, V);
        checks++;
        if (to || log_addr.size() != 32) begin
            failures++;
            $display("FAIL nominal_count got %0d timeout=%b expected 32", log_addr.size(), to);
        end
        checks++;
        if (log_addr.size() != 32 || log_addr[0] !== 32'h0 || log_data[0] !== 8'h00 ||
            log_addr[31] !== 32'h1F || log_data[31] !== 8'h0A) begin
            failures++;
            $display("FAIL nominal_first_last got %0d writes expected first 0/00 last 1f/0a", log_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL nominal_write[%0d] got %h/%h expected %h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_busy_bad != 0) begin
            failures++;
            $display("FAIL nominal_done got pulses=%0d busy_with_done=%0d expected 1 0", done_cnt, done_busy_bad);
        end
        checks++;
        if ({line_err, frame_err, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL nominal_flags got %b%b%b expected 000", line_err, frame_err, overrun);
        end
    endtask

    task automatic test_select();
        bit to;
        for (int l = 0; l < V; l++) line_len[l] = H;
        clear_log();
        start_capture(1'b1);
        send_frame(V, 1, 0);
        wait_idle(to);
        build_exp(B1, V);
        checks++;
        if (to || log_addr.size() != 32) begin
            failures++;
            $display("FAIL select_count got %0d timeout=%b expected 32", log_addr.size(), to);
        end
        checks++;
        if (log_addr.size() != 32 || log_addr[0] !== 32'h0004_B000 || log_addr[31] !== 32'h0004_B01F) begin
            failures++;
            $display("FAIL select_first_last got %0d writes expected 0004b000..0004b01f", log_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL select_write[%0d] got %h/%h expected %h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL select_done got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_line_err();
        bit to;
        for (int l = 0; l < V; l++) line_len[l] = H;
        line_len[1] = H + 1;
        line_len[2] = H - 1;
        clear_log();
        start_capture(1'b0);
        send_frame(V, 0, 0);
        wait_idle(to);
        build_exp(B0, V);
        checks++;
        if (to || log_addr.size() != 31) begin
            failures++;
            $display("FAIL lerr_count got %0d timeout=%b expected 31", log_addr.size(), to);
        end
        checks++;
        if (log_addr.size() != 31 || log_addr[16] !== 32'd16 || log_addr[22] !== 32'd22 || log_addr[23] !== 32'd24) begin
            failures++;
            $display("FAIL lerr_line2_span got %0d writes expected line 2 at 16..22 and line 3 from 24", log_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL lerr_write[%0d] got %h/%h expected %h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if ({line_err, frame_err, overrun} !== 3'b100) begin
            failures++;
            $display("FAIL lerr_flags got %b%b%b expected 100", line_err, frame_err, overrun);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL lerr_done got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_frame_short();
        bit to;
        for (int l = 0; l < V; l++) line_len[l] = H;
        clear_log();
        start_capture(1'b0);
        send_frame(2, 0, 0);
        wait_idle(to);
        checks++;
        if (to || log_addr.size() != 16 || log_addr[15] !== 32'd15) begin
            failures++;
            $display("FAIL short_count got %0d timeout=%b expected 16 ending at 0000000f", log_addr.size(), to);
        end
        checks++;
        if ({line_err, frame_err, overrun} !== 3'b010) begin
            failures++;
            $display("FAIL short_flags got %b%b%b expected 010", line_err, frame_err, overrun);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL short_done got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int l = 0; l < V; l++) line_len[l] = H;
        clear_log();
        start_capture(1'b0);
        send_frame(V, 0, 1);
        wait_idle(to);
        checks++;
        if (to || frame_err !== 1'b0 || log_addr.size() != 32 || done_cnt != 1) begin
            failures++;
            $display("FAIL coincide_full got frame_err=%b writes=%0d done=%0d expected 0 32 1", frame_err, log_addr.size(), done_cnt);
        end
        clear_log();
        start_capture(1'b0);
        send_frame(2, 0, 1);
        wait_idle(to);
        checks++;
        if (to || frame_err !== 1'b1 || log_addr.size() != 16 || done_cnt != 1) begin
            failures++;
            $display("FAIL coincide_short got frame_err=%b writes=%0d done=%0d expected 1 16 1", frame_err, log_addr.size(), done_cnt);
        end
    endtask

    task automatic test_overrun_reset();
        for (int l = 0; l < V; l++) line_len[l] = H;
        clear_log();
        start_capture(1'b0);
        smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0);
        wr_ready = 1'b0;
        smp(1, 1, 8'hA0);
        smp(1, 1, 8'hA1);
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_address !== 32'd0 || wr_data !== 8'hA0) begin
            failures++;
            $display("FAIL ovr_held got en=%b addr=%h data=%h expected 1 00000000 a0", wr_en, wr_address, wr_data);
        end
        checks++;
        if (overrun !== 1'b1 || log_addr.size() != 0) begin
            failures++;
            $display("FAIL ovr_flag got overrun=%b writes=%0d expected 1 0", overrun, log_addr.size());
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        smp(1, 1, 8'hA2);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'd0 || log_data[0] !== 8'hA0 ||
            log_addr[1] !== 32'd2 || log_data[1] !== 8'hA2) begin
            failures++;
            $display("FAIL ovr_accepted got %0d writes expected 0/a0 then 2/a2", log_addr.size());
        end
        wr_ready = 1'b0;
        smp(1, 1, 8'hA3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_address, wr_data, busy, done, line_err, frame_err, overrun} !== 46'd0) begin
            failures++;
            $display("FAIL rst_mid got en=%b addr=%h data=%h busy=%b done=%b flags=%b%b%b expected all 0",
                     wr_en, wr_address, wr_data, busy, done, line_err, frame_err, overrun);
        end
        @(posedge clk); #1;
        smp(1, 1, 8'hA4); smp(1, 0, 0); smp(0, 0, 0); smp(1, 0, 0);
        checks++;
        if (done_cnt != 0 || log_addr.size() != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done got done=%0d writes=%0d busy=%b expected 0 2 0", done_cnt, log_addr.size(), busy);
        end
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
        pixel = 8'h00; image_select = 1'b0; start = 1'b0; wr_ready = 1'b1;
        test_reset();
        test_nominal();
        test_select();
        test_line_err();
        test_frame_short();
        test_back_to_back();
        test_overrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
